// File: rtl/alu_issue_if.sv
// Fetch, register-file, execute and writeback signals of the ALU issue stage.
// The slave modport is the issue stage itself; master is its environment.
interface alu_issue_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [3:0]       rf_raddr_a;
  logic [3:0]       rf_raddr_b;
  logic [31:0]      rf_rdata_a;
  logic [31:0]      rf_rdata_b;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       operation;
  logic [31:0]      operand_a;
  logic [31:0]      operand_b;
  logic [3:0]       out_rd;
  logic             wb_valid;
  logic [3:0]       wb_rd;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, in_instr, rf_rdata_a, rf_rdata_b, out_ready, wb_valid, wb_rd,
    output in_ready, rf_raddr_a, rf_raddr_b, out_valid, operation, operand_a,
           operand_b, out_rd, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, rf_rdata_a, rf_rdata_b, out_ready, wb_valid, wb_rd,
    input  in_ready, rf_raddr_a, rf_raddr_b, out_valid, operation, operand_a,
           operand_b, out_rd, illegal_cnt
  );
endinterface

// File: rtl/alu_issue.sv
// Decode/issue stage: decodes fetched instructions, reads the register file and
// hands one registered ALU bundle to execute, stalling on busy-bit hazards.
module alu_issue #(
  parameter int unsigned CNT_W      = 8,
  parameter bit          SEXT_ARITH = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_issue_if.slave bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned NREG   = 16;
  localparam int unsigned IMM_W  = 16;
  // Op codes 0..2 (ADD/SUB/MULT) are the arithmetic ops; 7 is unassigned.
  localparam logic [OP_W-1:0] OP_MULT    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(7);

  logic             imm_sel;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0] imm;

  logic             out_valid_q, out_valid_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            illegal, hazard, slot_free, in_ready_c;
  logic            legal_acc, illegal_acc;
  logic [XLEN-1:0] imm_ext;

  assign {imm_sel, op, rd, rs1, rs2, imm} = bus.in_instr;

  // Hazard check uses registered busy bits only; writeback is seen one cycle later.
  always_comb begin
    illegal     = (op == OP_ILLEGAL);
    hazard      = busy_q[rs1] | (~imm_sel & busy_q[rs2]) | busy_q[rd];
    slot_free   = ~out_valid_q | bus.out_ready;
    in_ready_c  = illegal ? slot_free : (slot_free & ~hazard);
    legal_acc   = bus.in_valid & in_ready_c & ~illegal;
    illegal_acc = bus.in_valid & in_ready_c & illegal;
    imm_ext     = (SEXT_ARITH && (op <= OP_MULT)) ? {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm}
                                                  : {{(XLEN-IMM_W){1'b0}}, imm};
  end

  always_comb begin
    out_valid_d = out_valid_q & ~bus.out_ready;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    if (legal_acc) begin
      out_valid_d = 1'b1;
      op_d        = op;
      a_d         = (rs1 == '0) ? '0 : bus.rf_rdata_a;
      b_d         = imm_sel ? imm_ext : ((rs2 == '0) ? '0 : bus.rf_rdata_b);
      rd_d        = rd;
    end
    if (illegal_acc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Clear first so that a same-cycle issue to the same register keeps it busy.
    if (bus.wb_valid) begin
      busy_d[bus.wb_rd] = 1'b0;
    end
    if (legal_acc) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      busy_q      <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.rf_raddr_a  = rs1;
  assign bus.rf_raddr_b  = rs2;
  assign bus.out_valid   = out_valid_q;
  assign bus.operation   = op_q;
  assign bus.operand_a   = a_q;
  assign bus.operand_b   = b_q;
  assign bus.out_rd      = rd_q;
  assign bus.illegal_cnt = cnt_q;
endmodule
